// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage pipeline: EX forwarding, load-use stall, branch flush, MDU hold.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipeline_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteM,
  input  logic              regWriteW,
  input  logic              memReadE,
  input  logic              pcSrcE,
  input  logic              mduStartE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              mduBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  flushCnt
`endif
);

  localparam int              CW        = $clog2(MDU_LAT) + 1;
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]   CNT_LOAD  = CW'(MDU_LAT - 1);
  localparam logic            MDU_MULTI = (MDU_LAT > 1);
  localparam logic [REG_AW-1:0] X0      = {REG_AW{1'b0}};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          lw_stall;
  logic          mdu_stall;

  // MEM wins over WB so equal destinations forward the younger result
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_w,
                                         input logic [REG_AW-1:0] rd_w);
    logic [1:0] sel;
    if (we_m && (rd_m != X0) && (rd_m == src)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != X0) && (rd_w == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // MDU occupancy counter next state
  always_comb begin
    cnt_d = cnt_q;
    if (mduStartE && (cnt_q == CNT_ZERO)) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // MDU occupancy counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Hazard detection and stall/flush outputs; the MDU stall blocks any EX bubble
  always_comb begin
    forwardAE = fwd_sel(rs1E, regWriteM, rdM, regWriteW, rdW);
    forwardBE = fwd_sel(rs2E, regWriteM, rdM, regWriteW, rdW);
    lw_stall  = memReadE && (rdE != X0) && ((rdE == rs1D) || (rdE == rs2D));
    mdu_stall = mduStartE && (cnt_q != CNT_ONE) && MDU_MULTI;
    stallF    = lw_stall || mdu_stall;
    stallD    = lw_stall || mdu_stall;
    stallE    = mdu_stall;
    flushM    = mdu_stall;
    flushD    = pcSrcE && !mdu_stall;
    flushE    = (lw_stall || pcSrcE) && !mdu_stall;
    mduBusy   = (cnt_q != CNT_ZERO);
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] PERF_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PERF_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  // Saturating performance counter next state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallF && (stall_cnt_q != PERF_MAX)) begin
      stall_cnt_d = stall_cnt_q + PERF_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if ((flushD || flushE) && (flush_cnt_q != PERF_MAX)) begin
      flush_cnt_d = flush_cnt_q + PERF_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: MDU_LAT=4 main instance plus an MDU_LAT=1, CNT_W=2 instance.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regWriteM, regWriteW, memReadE, pcSrcE, mduStartE;

  logic [1:0] forwardAE, forwardBE;
  logic       stallF, stallD, stallE, flushD, flushE, flushM, mduBusy;
  logic [1:0] u1_fa, u1_fb;
  logic       u1_sf, u1_sd, u1_se, u1_fd, u1_fe, u1_fm, u1_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt;
  logic [1:0]  u1_stallCnt, u1_flushCnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_AW(5), .MDU_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memReadE(memReadE), .pcSrcE(pcSrcE), .mduStartE(mduStartE),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .flushD(flushD), .flushE(flushE), .flushM(flushM), .mduBusy(mduBusy)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCnt(stallCnt), .flushCnt(flushCnt)
`endif
  );

  pipeline_hazard_unit #(.REG_AW(5), .MDU_LAT(1), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memReadE(memReadE), .pcSrcE(pcSrcE), .mduStartE(mduStartE),
    .forwardAE(u1_fa), .forwardBE(u1_fb), .stallF(u1_sf), .stallD(u1_sd),
    .stallE(u1_se), .flushD(u1_fd), .flushE(u1_fe), .flushM(u1_fm), .mduBusy(u1_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCnt(u1_stallCnt), .flushCnt(u1_flushCnt)
`endif
  );

  typedef struct {
    string       tag;
    logic [10:0] exp;
    bit          chk1;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  // ctl bit order: stallF stallD stallE flushD flushE flushM mduBusy
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0001100;
  localparam logic [6:0] C_MDU0 = 7'b1110010;
  localparam logic [6:0] C_MDUB = 7'b1110011;
  localparam logic [6:0] C_BUSY = 7'b0000001;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [10:0] ex(input logic [1:0] fa, input logic [1:0] fb, input logic [6:0] ctl);
    return {fa, fb, ctl};
  endfunction

  task automatic idle();
    rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
    rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
    regWriteM = 1'b0; regWriteW = 1'b0; memReadE = 1'b0; pcSrcE = 1'b0; mduStartE = 1'b0;
  endtask

  // push the expectation for the cycle whose inputs are now applied, then advance one clock
  task automatic step(input string tag, input logic [10:0] e, input bit c1);
    exp_t item;
    item.tag  = tag;
    item.exp  = e;
    item.chk1 = c1;
    exp_q.push_back(item);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check_val(cur.tag,
                {21'd0, forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, flushM, mduBusy},
                {21'd0, cur.exp});
      if (cur.chk1) begin
        check_val({cur.tag, "_lat1"}, {28'd0, u1_sf, u1_se, u1_fm, u1_busy}, 32'd0);
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step("reset", ex(2'b00, 2'b00, C_NONE), 1'b1);
    reset = 1'b0;

    regWriteM = 1'b1; rdM = 5'd5; rs1E = 5'd5; regWriteW = 1'b1; rdW = 5'd5;
    step("fwdA_mem", ex(2'b10, 2'b00, C_NONE), 1'b0);
    rdM = 5'd0;
    step("fwdA_wb", ex(2'b01, 2'b00, C_NONE), 1'b0);
    rs1E = 5'd0;
    step("fwdA_x0", ex(2'b00, 2'b00, C_NONE), 1'b0);
    idle(); regWriteM = 1'b1; rdM = 5'd3; rs1E = 5'd3; regWriteW = 1'b1; rdW = 5'd9; rs2E = 5'd9;
    step("fwdB_wb", ex(2'b10, 2'b01, C_NONE), 1'b0);
    regWriteW = 1'b0;
    step("fwdB_nowe", ex(2'b10, 2'b00, C_NONE), 1'b0);
    idle(); regWriteM = 1'b1; regWriteW = 1'b1; rdM = 5'd4; rdW = 5'd4; rs1E = 5'd4; rs2E = 5'd4;
    step("fwd_equal", ex(2'b10, 2'b10, C_NONE), 1'b0);

    idle(); memReadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
    step("lu_rs2", ex(2'b00, 2'b00, C_LU), 1'b0);
    rdE = 5'd0;
    step("lu_rd0", ex(2'b00, 2'b00, C_NONE), 1'b0);
    rdE = 5'd12; rs1D = 5'd12; rs2D = 5'd0;
    step("lu_rs1", ex(2'b00, 2'b00, C_LU), 1'b0);
    memReadE = 1'b0;
    step("lu_noload", ex(2'b00, 2'b00, C_NONE), 1'b0);

    idle(); pcSrcE = 1'b1;
    step("branch", ex(2'b00, 2'b00, C_BR), 1'b0);

    for (int k = 0; k < 3; k++) begin
      idle(); mduStartE = 1'b1;
      step("mdu_c0", ex(2'b00, 2'b00, C_MDU0), 1'b1);
      step("mdu_c1", ex(2'b00, 2'b00, C_MDUB), 1'b1);
      step("mdu_c2", ex(2'b00, 2'b00, C_MDUB), 1'b1);
      step("mdu_c3", ex(2'b00, 2'b00, C_BUSY), 1'b1);
    end
    idle();
    step("mdu_done", ex(2'b00, 2'b00, C_NONE), 1'b1);

    mduStartE = 1'b1; memReadE = 1'b1; rdE = 5'd7; rs1D = 5'd7;
    step("mdulu_c0", ex(2'b00, 2'b00, C_MDU0), 1'b0);
    step("mdulu_c1", ex(2'b00, 2'b00, C_MDUB), 1'b0);
    step("mdulu_c2", ex(2'b00, 2'b00, C_MDUB), 1'b0);
    step("mdulu_rel", ex(2'b00, 2'b00, 7'b1100101), 1'b0);
    idle();
    step("mdulu_idle", ex(2'b00, 2'b00, C_NONE), 1'b0);

    mduStartE = 1'b1; pcSrcE = 1'b1;
    step("mdubr_c0", ex(2'b00, 2'b00, C_MDU0), 1'b0);
    step("mdubr_c1", ex(2'b00, 2'b00, C_MDUB), 1'b0);
    step("mdubr_c2", ex(2'b00, 2'b00, C_MDUB), 1'b0);
    step("mdubr_rel", ex(2'b00, 2'b00, 7'b0001101), 1'b0);
    idle();
    step("mdubr_idle", ex(2'b00, 2'b00, C_NONE), 1'b0);

    mduStartE = 1'b1;
    step("rstmid_c0", ex(2'b00, 2'b00, C_MDU0), 1'b1);
    reset = 1'b1;
    step("rstmid_c1", ex(2'b00, 2'b00, C_MDUB), 1'b1);
    reset = 1'b0; idle();
    step("rstmid_after", ex(2'b00, 2'b00, C_NONE), 1'b1);

    mduStartE = 1'b1;
    step("xfl_c0", ex(2'b00, 2'b00, C_MDU0), 1'b1);
    idle();
    step("xfl_c1", ex(2'b00, 2'b00, C_BUSY), 1'b1);
    step("xfl_c2", ex(2'b00, 2'b00, C_BUSY), 1'b1);
    step("xfl_c3", ex(2'b00, 2'b00, C_BUSY), 1'b1);
    step("xfl_c4", ex(2'b00, 2'b00, C_NONE), 1'b1);

`ifdef HAZARD_PERF_CNT_EN
    reset = 1'b1;
    step("perf_rst", ex(2'b00, 2'b00, C_NONE), 1'b1);
    reset = 1'b0;
    check_val("perf_rst_stall", stallCnt, 32'd0);
    check_val("perf_rst_flush", flushCnt, 32'd0);
    mduStartE = 1'b1;
    step("perf_m0", ex(2'b00, 2'b00, C_MDU0), 1'b1);
    step("perf_m1", ex(2'b00, 2'b00, C_MDUB), 1'b1);
    step("perf_m2", ex(2'b00, 2'b00, C_MDUB), 1'b1);
    step("perf_m3", ex(2'b00, 2'b00, C_BUSY), 1'b1);
    idle(); pcSrcE = 1'b1;
    step("perf_br", ex(2'b00, 2'b00, C_BR), 1'b0);
    check_val("perf_stall3", stallCnt, 32'd3);
    check_val("perf_flush1", flushCnt, 32'd1);
    check_val("perf_lat1_stall0", {30'd0, u1_stallCnt}, 32'd0);
    check_val("perf_lat1_flush1", {30'd0, u1_flushCnt}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      step("perf_br_n", ex(2'b00, 2'b00, C_BR), 1'b0);
    end
    idle(); memReadE = 1'b1; rdE = 5'd6; rs2D = 5'd6;
    for (int k = 0; k < 5; k++) begin
      step("perf_lu_n", ex(2'b00, 2'b00, C_LU), 1'b0);
    end
    idle();
    check_val("perf_stall8", stallCnt, 32'd8);
    check_val("perf_flush11", flushCnt, 32'd11);
    check_val("perf_sat_stall", {30'd0, u1_stallCnt}, 32'd3);
    check_val("perf_sat_flush", {30'd0, u1_flushCnt}, 32'd3);
`endif

    @(negedge clk);
    check_val("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Central hazard controller for the 5-stage RISC-V pipeline. It generates the EX-stage operand forwarding selects, detects load-use hazards, and flushes the pipeline on taken branches and jumps. It also sequences a multi-cycle multiply/divide unit (MDU) with an internal cycle counter that holds the instruction in EX. It sits beside the pipeline registers and drives their stall and flush enables.

## Interface
- `REG_AW`, 5: register address width; `x0` is address 0.
- `MDU_LAT`, 4: MDU occupancy in EX, in cycles; legal range 1..64.
- `CNT_W`, 32: width of the performance counters, used only when `HAZARD_PERF_CNT_EN` is defined.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high reset
- `rs1D`, `rs2D`  in  REG_AW  source registers in decode
- `rs1E`, `rs2E`  in  REG_AW  source registers in execute
- `rdE`, `rdM`, `rdW`  in  REG_AW  destination registers in EX, MEM and WB
- `regWriteM`, `regWriteW`  in  1  register-write enables in MEM and WB
- `memReadE`  in  1  load instruction is in EX
- `pcSrcE`  in  1  taken branch or jump resolved in EX
- `mduStartE`  in  1  MDU instruction is in EX
- `forwardAE`, `forwardBE`  out  2  forwarding selects: 00 = register file, 01 = WB, 10 = MEM
- `stallF`, `stallD`, `stallE`  out  1  hold the PC, IF/ID and ID/EX registers
- `flushD`, `flushE`, `flushM`  out  1  clear IF/ID, ID/EX and EX/MEM to a bubble
- `mduBusy`  out  1  MDU counter is non-zero
- `stallCnt`, `flushCnt`  out  CNT_W  performance counters (only when `HAZARD_PERF_CNT_EN` is defined)

## Operation
- Forwarding (combinational), evaluated independently for A (`rs1E`) and B (`rs2E`):
  - MEM first: if `regWriteM` is high, `rdM` is not 0 and `rdM` matches the source, select 10.
  - Otherwise WB: if `regWriteW` is high, `rdW` is not 0 and `rdW` matches the source, select 01.
  - Otherwise select 00. A source of `x0` always selects 00.
- Load-use detection:
  - `lwStall` = `memReadE` & (`rdE` ≠ 0) & (`rdE` == `rs1D` | `rdE` == `rs2D`).
- MDU counter `cnt`:
  - Width is clog2(MDU_LAT)+1 bits.
  - If `mduStartE` is high and `cnt` is 0, load MDU_LAT-1.
  - Else if `cnt` is not 0, decrement.
  - Otherwise hold.
- MDU stall: `mduStall` = `mduStartE` & (`cnt` ≠ 1) & (MDU_LAT > 1).
  - The MDU instruction therefore stays in EX for exactly MDU_LAT cycles.
  - When MDU_LAT is 1, `mduStall` is never asserted.
- Output equations:
  - `stallF` = `stallD` = `lwStall` | `mduStall`
  - `stallE` = `mduStall`
  - `flushM` = `mduStall`
  - `flushD` = `pcSrcE` & ~`mduStall`
  - `flushE` = (`lwStall` | `pcSrcE`) & ~`stallE`
  - `mduBusy` = (`cnt` ≠ 0)
- Priority rules:
  - `mduStall` dominates `lwStall`. The instruction in EX is never bubbled while it is stalled; the load-use bubble is inserted once the MDU releases.
  - `pcSrcE` and `mduStartE` are mutually exclusive by decode. If both arrive, the stall wins and the flush is deferred.
  - Equal `rdM` and `rdW` resolve to MEM, the younger result.

## Timing
- Every output except the counters is combinational from the current inputs and `cnt`; there is no added latency.
- `cnt` updates on the rising edge of `clk`.
- On reset:
  - `cnt` is 0 and `mduBusy` is 0.
  - With inactive inputs, all stall and flush outputs are 0 and the forwarding selects are 00.
  - Counters are cleared to 0.
- Reset asserted mid-MDU clears `cnt` on the next edge; the stall drops in that same cycle if `mduStartE` is low.
- If `mduStartE` drops while `cnt` is non-zero (an external flush), `cnt` keeps counting down to 0 and no stall is generated.
- Consecutive MDU instructions: the second one sees `cnt` = 0 on its first EX cycle and reloads the counter. There is no idle gap.

## Configuration
- `HAZARD_PERF_CNT_EN`, when defined:
  - `stallCnt` increments on every cycle with `stallF` high.
  - `flushCnt` increments on every cycle with `flushD` | `flushE` high.
  - Both saturate at all-ones and clear on `reset`.
- When undefined, the counter ports and their logic are absent.

## Test plan
- Forwarding A: `regWriteM`=1, `rdM`=5, `rs1E`=5, `regWriteW`=1, `rdW`=5 → `forwardAE`=10. Set `rdM`=0 → 01. Set `rs1E`=0 → 00.
- Load-use: `memReadE`=1, `rdE`=7, `rs2D`=7 → `stallF`=`stallD`=`flushE`=1 for one cycle, `flushD`=0. With `rdE`=0 → no stall.
- Branch: `pcSrcE`=1 → `flushD`=`flushE`=1, no stalls.
- MDU, MDU_LAT=4: hold `mduStartE` → stall and `flushM` high for 3 cycles, low in the 4th. `mduBusy` high for 3 cycles, starting one cycle after issue. MDU_LAT=1 → no stall.
- MDU plus load-use: MDU in EX, `lwStall` true in D → `flushE`=0 while stalled. After release, `lwStall` bubble inserted. Reset asserted during the 2nd stall cycle → `cnt`=0 next cycle.
- Perf (`HAZARD_PERF_CNT_EN`): the MDU_LAT=4 sequence followed by one branch → `stallCnt`=3, `flushCnt`=1. Saturation checked with CNT_W=2.
